// File: rtl/cmp_mon_pkg.sv
// Shared types and helpers for the comparator result monitor.
package cmp_mon_pkg;

  // Committed or candidate relation between the compared operands.
  typedef enum logic [1:0] {
    REL_UNKNOWN = 2'b00,
    REL_LT      = 2'b01,
    REL_EQ      = 2'b10,
    REL_GT      = 2'b11
  } rel_t;

  // Qualification FSM: IDLE has no candidate, QUALIFY holds one.
  typedef enum logic {
    IDLE,
    QUALIFY
  } mon_state_t;

  // True when exactly one of the three comparator flags is set.
  function automatic logic onehot3(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

endpackage

// File: rtl/cmp_sat_counter.sv
// Saturating event counter: rst and clr both zero it, inc stops at all-ones.
module cmp_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over increment; hold once saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cmp_result_monitor.sv
// Qualifies comparator eq/gt/lt flags: commits a relation only after it
// persists for STABLE_CNT consecutive valid samples, flags illegal samples,
// and counts commits per relation.
module cmp_result_monitor
  import cmp_mon_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  input  logic             clr_counts,
  output logic [1:0]       rel_state,
  output logic             change_pulse,
  output logic             illegal,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] lt_events,
  output logic [CNT_W-1:0] eq_events,
  output logic [CNT_W-1:0] gt_events
);

  localparam logic [3:0] STABLE_TGT = 4'(STABLE_CNT);

  mon_state_t state_q, state_d;
  rel_t       cand_q, cand_d;
  rel_t       rel_q, rel_d;
  logic [3:0] run_q, run_d;
  logic       change_q, change_d;
  logic       illegal_q, illegal_d;
  logic       sticky_q, sticky_d;
  logic       inc_lt, inc_eq, inc_gt;

  rel_t       samp_rel;
  logic       samp_legal;
  logic [3:0] run_next;

  // Decode the incoming sample into a relation and a legality flag.
  always_comb begin
    samp_legal = onehot3(eq, gt, lt);
    samp_rel   = REL_UNKNOWN;
    if (eq) begin
      samp_rel = REL_EQ;
    end else if (gt) begin
      samp_rel = REL_GT;
    end else if (lt) begin
      samp_rel = REL_LT;
    end
  end

  // Next-state: qualification FSM, committed relation, pulses and sticky error.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    rel_d     = rel_q;
    run_d     = run_q;
    change_d  = 1'b0;
    illegal_d = 1'b0;
    sticky_d  = sticky_q;
    inc_lt    = 1'b0;
    inc_eq    = 1'b0;
    inc_gt    = 1'b0;
    run_next  = 4'd1;

    if (in_valid) begin
      if (!samp_legal) begin
        illegal_d = 1'b1;
        sticky_d  = 1'b1;
        run_d     = '0;
        cand_d    = REL_UNKNOWN;
        state_d   = IDLE;
      end else if (samp_rel == rel_q) begin
        run_d   = '0;
        cand_d  = REL_UNKNOWN;
        state_d = IDLE;
      end else begin
        if ((state_q == QUALIFY) && (samp_rel == cand_q)) begin
          run_next = run_q + 4'd1;
        end
        if (run_next == STABLE_TGT) begin
          rel_d    = samp_rel;
          change_d = 1'b1;
          inc_lt   = (samp_rel == REL_LT);
          inc_eq   = (samp_rel == REL_EQ);
          inc_gt   = (samp_rel == REL_GT);
          run_d    = '0;
          cand_d   = REL_UNKNOWN;
          state_d  = IDLE;
        end else begin
          run_d   = run_next;
          cand_d  = samp_rel;
          state_d = QUALIFY;
        end
      end
    end

    if (clr_counts) begin
      sticky_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cand_q    <= REL_UNKNOWN;
      rel_q     <= REL_UNKNOWN;
      run_q     <= '0;
      change_q  <= 1'b0;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      rel_q     <= rel_d;
      run_q     <= run_d;
      change_q  <= change_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
    end
  end

  cmp_sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_counts),
    .inc   (inc_lt),
    .count (lt_events)
  );

  cmp_sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_counts),
    .inc   (inc_eq),
    .count (eq_events)
  );

  cmp_sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_counts),
    .inc   (inc_gt),
    .count (gt_events)
  );

  assign rel_state      = rel_q;
  assign change_pulse   = change_q;
  assign illegal        = illegal_q;
  assign illegal_sticky = sticky_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Testbench for cmp_result_monitor: three instances share stimulus
// (STABLE_CNT=3/CNT_W=8, STABLE_CNT=3/CNT_W=2, STABLE_CNT=1/CNT_W=8)
// and are compared each cycle against a behavioural model.
module tb_cmp_result_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic eq = 1'b0;
  logic gt = 1'b0;
  logic lt = 1'b0;
  logic clr_counts = 1'b0;

  logic [1:0] rel_a, rel_b, rel_c;
  logic       chg_a, chg_b, chg_c;
  logic       ill_a, ill_b, ill_c;
  logic       stk_a, stk_b, stk_c;
  logic [7:0] lt_a, eq_a, gt_a, lt_c, eq_c, gt_c;
  logic [1:0] lt_b, eq_b, gt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmp_result_monitor #(.STABLE_CNT(3), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt),
    .clr_counts(clr_counts), .rel_state(rel_a), .change_pulse(chg_a),
    .illegal(ill_a), .illegal_sticky(stk_a),
    .lt_events(lt_a), .eq_events(eq_a), .gt_events(gt_a)
  );

  cmp_result_monitor #(.STABLE_CNT(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt),
    .clr_counts(clr_counts), .rel_state(rel_b), .change_pulse(chg_b),
    .illegal(ill_b), .illegal_sticky(stk_b),
    .lt_events(lt_b), .eq_events(eq_b), .gt_events(gt_b)
  );

  cmp_result_monitor #(.STABLE_CNT(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt),
    .clr_counts(clr_counts), .rel_state(rel_c), .change_pulse(chg_c),
    .illegal(ill_c), .illegal_sticky(stk_c),
    .lt_events(lt_c), .eq_events(eq_c), .gt_events(gt_c)
  );

  // Observed outputs packed as {rel, change, illegal, sticky, lt, eq, gt}.
  logic [28:0] obs [3];
  assign obs[0] = {rel_a, chg_a, ill_a, stk_a, lt_a, eq_a, gt_a};
  assign obs[1] = {rel_b, chg_b, ill_b, stk_b, 6'd0, lt_b, 6'd0, eq_b, 6'd0, gt_b};
  assign obs[2] = {rel_c, chg_c, ill_c, stk_c, lt_c, eq_c, gt_c};

  // Behavioural model. Relation codes: 0 unknown, 1 lt, 2 eq, 3 gt.
  int m_stable [3] = '{3, 3, 1};
  int m_max    [3] = '{255, 3, 255};
  int m_rel    [3];
  int m_cand   [3];
  int m_run    [3];
  int m_ev     [3][4];
  bit m_chg    [3];
  bit m_ill    [3];
  bit m_stk    [3];

  function automatic logic [28:0] exp_vec(input int k);
    return {2'(m_rel[k]), m_chg[k], m_ill[k], m_stk[k],
            8'(m_ev[k][1]), 8'(m_ev[k][2]), 8'(m_ev[k][3])};
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int nflags;
    int r;
    nflags = int'(eq) + int'(gt) + int'(lt);
    r = eq ? 2 : (gt ? 3 : 1);
    for (int k = 0; k < 3; k++) begin
      m_chg[k] = 1'b0;
      m_ill[k] = 1'b0;
      if (rst) begin
        m_rel[k] = 0; m_cand[k] = 0; m_run[k] = 0; m_stk[k] = 1'b0;
        for (int j = 0; j < 4; j++) m_ev[k][j] = 0;
      end else begin
        if (in_valid) begin
          if (nflags != 1) begin
            m_ill[k] = 1'b1;
            m_stk[k] = 1'b1;
            m_run[k] = 0; m_cand[k] = 0;
          end else if (r == m_rel[k]) begin
            m_run[k] = 0; m_cand[k] = 0;
          end else begin
            if (r == m_cand[k]) m_run[k]++;
            else begin m_cand[k] = r; m_run[k] = 1; end
            if (m_run[k] == m_stable[k]) begin
              m_rel[k] = r;
              m_chg[k] = 1'b1;
              if (m_ev[k][r] < m_max[k]) m_ev[k][r]++;
              m_run[k] = 0; m_cand[k] = 0;
            end
          end
        end
        if (clr_counts) begin
          m_stk[k] = 1'b0;
          for (int j = 0; j < 4; j++) m_ev[k][j] = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, sample 1 ns later.
  task automatic step(input logic r, input logic v, input logic e,
                      input logic g, input logic l, input logic c);
    rst = r; in_valid = v; eq = e; gt = g; lt = l; clr_counts = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Shorthand for a valid sample: 1=lt 2=eq 3=gt, 0 = invalid cycle.
  task automatic samp(input int r);
    step(1'b0, r != 0, r == 2, r == 3, r == 1, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== 29'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d: got %h expected %h", k, obs[k], 29'd0);
      end
    end
  endtask

  task automatic test_eq_commit();
    int seq [3] = '{2, 2, 2};
    for (int i = 0; i < 3; i++) begin
      samp(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL eq_commit step%0d inst%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
    end
    n_checks++;
    if (rel_a !== 2'b10 || chg_a !== 1'b1 || eq_a !== 8'd1) begin
      n_fail++;
      $display("FAIL eq_commit_final: got rel=%b chg=%b eq_ev=%0d expected rel=10 chg=1 eq_ev=1", rel_a, chg_a, eq_a);
    end
    samp(0);
    n_checks++;
    if (chg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL eq_commit_pulse_width: got chg=%b expected 0", chg_a);
    end
  endtask

  task automatic test_restart();
    int seq [6] = '{3, 3, 1, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      samp(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL restart step%0d inst%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
      if (i == 4) begin
        n_checks++;
        if (rel_a !== 2'b10) begin
          n_fail++;
          $display("FAIL restart_early: got rel=%b expected 10", rel_a);
        end
      end
    end
    n_checks++;
    if (rel_a !== 2'b11 || gt_a !== 8'd1 || lt_a !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_final: got rel=%b gt_ev=%0d lt_ev=%0d expected 11/1/0", rel_a, gt_a, lt_a);
    end
  endtask

  task automatic test_valid_gaps();
    int seq [10] = '{3, 0, 3, 0, 2, 2, 0, 0, 2, 0};
    for (int i = 0; i < 10; i++) begin
      samp(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL gaps step%0d inst%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
      if (i == 7) begin
        n_checks++;
        if (rel_a !== 2'b11) begin
          n_fail++;
          $display("FAIL gaps_hold: got rel=%b expected 11", rel_a);
        end
      end
    end
    n_checks++;
    if (rel_a !== 2'b10) begin
      n_fail++;
      $display("FAIL gaps_commit: got rel=%b expected 10", rel_a);
    end
  endtask

  task automatic test_illegal();
    samp(1);
    samp(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ill_a !== 1'b1 || stk_a !== 1'b1 || rel_a !== 2'b10) begin
      n_fail++;
      $display("FAIL illegal_pulse: got ill=%b stk=%b rel=%b expected 1/1/10", ill_a, stk_a, rel_a);
    end
    for (int i = 0; i < 3; i++) begin
      samp(1);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL illegal step%0d inst%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
      if (i == 0) begin
        n_checks++;
        if (ill_a !== 1'b0 || stk_a !== 1'b1) begin
          n_fail++;
          $display("FAIL illegal_one_cycle: got ill=%b stk=%b expected 0/1", ill_a, stk_a);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (rel_a !== 2'b10) begin
          n_fail++;
          $display("FAIL illegal_requalify: got rel=%b expected 10", rel_a);
        end
      end
    end
    n_checks++;
    if (rel_a !== 2'b01) begin
      n_fail++;
      $display("FAIL illegal_commit: got rel=%b expected 01", rel_a);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 6; i++) begin
        samp(i < 3 ? 1 : 3);
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (obs[k] !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL sat pair%0d step%0d inst%0d: got %h expected %h", p, i, k, obs[k], exp_vec(k));
          end
        end
      end
    end
    n_checks++;
    if (lt_b !== 2'd3 || gt_b !== 2'd3 || lt_a !== 8'd5 || gt_a !== 8'd5) begin
      n_fail++;
      $display("FAIL saturate: got b lt=%0d gt=%0d a lt=%0d gt=%0d expected 3/3/5/5", lt_b, gt_b, lt_a, gt_a);
    end
  endtask

  task automatic test_clr_commit();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // illegal -> sticky set
    samp(2);
    samp(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL clr_commit inst%0d: got %h expected %h", k, obs[k], exp_vec(k));
      end
    end
    n_checks++;
    if (rel_a !== 2'b10 || chg_a !== 1'b1 || eq_a !== 8'd0 || stk_a !== 1'b0 || gt_a !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_commit_a: got rel=%b chg=%b eq_ev=%0d stk=%b gt_ev=%0d expected 10/1/0/0/0",
               rel_a, chg_a, eq_a, stk_a, gt_a);
    end
    // illegal sample together with clr: pulse fires, sticky stays clear
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ill_a !== 1'b1 || stk_a !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_illegal: got ill=%b stk=%b expected 1/0", ill_a, stk_a);
    end
  endtask

  task automatic test_reset_in_qualify();
    samp(3);
    samp(3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== 29'd0) begin
        n_fail++;
        $display("FAIL reset_qualify inst%0d: got %h expected %h", k, obs[k], 29'd0);
      end
    end
    samp(3);
    n_checks++;
    if (rel_a !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_qualify_run: got rel=%b expected 00", rel_a);
    end
  endtask

  task automatic test_random();
    logic r, v, e, g, l, c;
    int   pick;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 49) == 0);
      pick = $urandom_range(0, 19);
      if (pick < 2) begin
        {e, g, l} = 3'($urandom_range(0, 7));
      end else begin
        pick = $urandom_range(1, 3);
        e = (pick == 2); g = (pick == 3); l = (pick == 1);
      end
      step(r, v, e, g, l, c);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random cyc%0d inst%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_eq_commit();
    test_restart();
    test_valid_gaps();
    test_illegal();
    test_saturation();
    test_clr_commit();
    test_reset_in_qualify();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_result_monitor.md
Name: cmp_result_monitor

Overview:
Sequential stage directly downstream of the 4-bit comparator. It consumes the comparator's eq/gt/lt flags and qualifies them. A relation is committed only after it persists for STABLE_CNT consecutive valid samples. Illegal flag combinations are flagged, and committed relation changes are counted per relation. Its outputs feed control logic that must not react to transient or glitching compare results.

Parameters:
STABLE_CNT, 3, consecutive identical legal valid samples required to commit a new relation (legal range 1..15)
CNT_W, 8, width of each per-relation event counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  eq/gt/lt sample is valid this cycle
eq  input  1  comparator equal flag
gt  input  1  comparator greater-than flag
lt  input  1  comparator less-than flag
clr_counts  input  1  synchronous clear of event counters and sticky error
rel_state  output  2  committed relation: 00 UNKNOWN, 01 LT, 10 EQ, 11 GT
change_pulse  output  1  one-cycle pulse when rel_state changes
illegal  output  1  one-cycle pulse, registered, for a valid sample that is not one-hot
illegal_sticky  output  1  set by any illegal sample; cleared by rst or clr_counts
lt_events  output  CNT_W  saturating count of commits to LT
eq_events  output  CNT_W  saturating count of commits to EQ
gt_events  output  CNT_W  saturating count of commits to GT

Behaviour:
- Reset (rst=1 at an edge): rel_state=UNKNOWN, run counter=0, candidate=UNKNOWN, and change_pulse, illegal, illegal_sticky and all counters = 0. rst has priority over everything else.
- Sample decode: a sample is legal when in_valid=1 and exactly one of {eq,gt,lt} is 1. The decoded relation R uses the encoding above.
- in_valid=0: no state change. The run counter and candidate are held, and the cycle is neither a break nor a count.
- Illegal valid sample (0, 2 or 3 flags set):
  - illegal=1 in the next cycle; illegal_sticky is set.
  - Run counter is cleared to 0 and candidate becomes UNKNOWN.
  - rel_state is held.
- Legal sample with R == rel_state: run counter is cleared and candidate becomes UNKNOWN.
- Legal sample with R != rel_state:
  - If R == candidate, run counter += 1.
  - Otherwise, candidate = R and run counter = 1.
- Commit: when the updated run count equals STABLE_CNT, on that same edge:
  - rel_state is set to R.
  - change_pulse=1 for exactly one cycle.
  - The counter for R increments.
  - Run counter clears to 0 and candidate becomes UNKNOWN.
  - Latency: rel_state reflects R in the cycle after the STABLE_CNT-th qualifying sample is presented.
- With STABLE_CNT=1, every legal differing sample commits with 1-cycle latency.
- States (FSM): IDLE (no candidate) and QUALIFY (candidate held, run counter 1..STABLE_CNT-1). Commits return to IDLE. rel_state is a separate register.
- Event counters saturate at all-ones and never wrap.
- clr_counts=1: all three counters and illegal_sticky go to 0 at the edge.
  - clr_counts wins over a simultaneous commit increment and over a simultaneous illegal sample's sticky set.
  - The illegal pulse still fires, and rel_state and change_pulse still update.
- UNKNOWN is never re-entered after the first commit except via rst.

Decomposition:
- Package cmp_mon_pkg holds:
  - relation typedef rel_t (2-bit enum: REL_UNKNOWN, REL_LT, REL_EQ, REL_GT)
  - FSM state typedef (IDLE, QUALIFY)
  - function onehot3 (legal-sample check)
- Sub-module cmp_sat_counter (parameter W; ports clk, rst, clr, inc, count), instantiated three times.

Test Plan:
1. Reset then hold eq=1, in_valid=1 for 3 cycles (STABLE_CNT=3) -> rel_state goes 00→10 one cycle after the 3rd sample; change_pulse high exactly 1 cycle; eq_events=1.
2. Committed EQ, then apply gt,gt,lt,gt,gt,gt -> the lt restarts qualification; GT commits only after the final three gt samples; gt_events=1, lt_events=0.
3. Committed GT, then apply gt,gt with in_valid=0 gaps between them, then eq,eq,(in_valid=0),eq -> rel_state stays 11 through the gt samples; EQ commits after the 3rd valid eq despite the gap.
4. Apply eq=1,gt=1 (valid) mid-qualification of LT after 2 lt samples -> illegal pulses 1 cycle and illegal_sticky=1; a further 3 lt samples are required to commit LT.
5. CNT_W=2: alternate 3×lt, 3×gt for 5 pairs -> lt_events and gt_events saturate at 3 and never wrap to 0.
6. Assert clr_counts on the same cycle as the commit-producing 3rd eq sample -> rel_state=EQ and change_pulse=1, but eq_events=0 and illegal_sticky=0 afterwards. Separately, assert rst during QUALIFY -> all outputs return to reset values on the next edge.
